// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch sequencer: state encoding and default
// step / reset-vector values.
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_NEXT  = 3'd2,
        ST_READ  = 3'd3,
        ST_LATCH = 3'd4,
        ST_REQ   = 3'd5
    } state_e;

    localparam int unsigned DEF_WORD_SIZE    = 32;
    localparam logic [31:0] DEF_PC_STEP      = 32'd4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'd0;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives pc_reg through write/read/latch per fetch and issues
// one instruction-memory request per PC value.
//
// state | meaning
// IDLE  | pc_reg untouched, waiting for start
// INIT  | write RESET_VECTOR into pc_reg
// NEXT  | write next PC (step or branch target); honours halt, then stall
// READ  | enable pc_reg output, its q updates on this edge
// LATCH | capture pc_reg q into the local PC copy
// REQ   | hold imem request until ack
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned           WORD_SIZE    = DEF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]  PC_STEP      = WORD_SIZE'(DEF_PC_STEP),
    parameter logic [WORD_SIZE-1:0]  RESET_VECTOR = WORD_SIZE'(DEF_RESET_VECTOR)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_halt,
    input  logic                 i_stall,
    input  logic                 i_branch_valid,
    input  logic [WORD_SIZE-1:0] i_branch_target,
    input  logic [WORD_SIZE-1:0] i_pc_q,
    output logic                 o_pc_cs,
    output logic                 o_pc_we,
    output logic                 o_pc_oe,
    output logic [WORD_SIZE-1:0] o_pc_d,
    output logic                 o_imem_req,
    output logic [WORD_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_ack,
    output logic                 o_fetch_valid,
    output logic [WORD_SIZE-1:0] o_fetch_pc,
    output logic                 o_busy
);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] target_q, target_d;
    logic                 br_pend_q, br_pend_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            target_q  <= '0;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            br_pend_q <= br_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        br_pend_d     = br_pend_q;
        o_pc_cs       = 1'b0;
        o_pc_we       = 1'b0;
        o_pc_oe       = 1'b0;
        o_pc_d        = '0;
        o_imem_req    = 1'b0;
        o_imem_addr   = '0;
        o_fetch_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_INIT;
            end
            ST_INIT: begin
                o_pc_cs = 1'b1;
                o_pc_we = 1'b1;
                o_pc_d  = RESET_VECTOR;
                state_d = ST_READ;
            end
            ST_READ: begin
                o_pc_cs = 1'b1;
                o_pc_oe = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                pc_d    = i_pc_q;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                o_imem_req  = 1'b1;
                o_imem_addr = pc_q;
                if (i_imem_ack) begin
                    o_fetch_valid = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (i_halt) begin
                    state_d = ST_IDLE;
                end else if (!i_stall) begin
                    o_pc_cs   = 1'b1;
                    o_pc_we   = 1'b1;
                    o_pc_d    = br_pend_q ? target_q : pc_q + PC_STEP;
                    br_pend_d = 1'b0;
                    state_d   = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe coinciding with the NEXT write is kept for the following fetch.
        if (state_q != ST_IDLE && i_branch_valid) begin
            br_pend_d = 1'b1;
            target_d  = i_branch_target;
        end
    end

    assign o_fetch_pc = pc_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the program-counter register (`pc_reg`). It owns the register's chip-select, write-enable, output-enable and data-in lines, and runs a fixed write/read/latch sequence per fetch. It issues one instruction-memory request per PC value and advances the PC by a fixed step or to a branch target. It sits between the decode/branch logic and the PC register / instruction memory in the training CPU.

## Interface
Parameters:
- WORD_SIZE, 32, PC / address width
- PC_STEP, 4, increment added per sequential fetch
- RESET_VECTOR, 0, first PC written after start

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_start  in  1  begin fetching from RESET_VECTOR; sampled only in IDLE
- i_halt  in  1  stop after the current fetch completes; return to IDLE
- i_stall  in  1  hold PC update while high
- i_branch_valid  in  1  one-cycle strobe: redirect next PC
- i_branch_target  in  WORD_SIZE  redirect address, valid with strobe
- i_pc_q  in  WORD_SIZE  pc_reg data output
- o_pc_cs  out  1  pc_reg chip select
- o_pc_we  out  1  pc_reg write enable
- o_pc_oe  out  1  pc_reg output enable
- o_pc_d  out  WORD_SIZE  pc_reg write data
- o_imem_req  out  1  instruction fetch request, held until ack
- o_imem_addr  out  WORD_SIZE  fetch address, stable while req high
- i_imem_ack  in  1  one-cycle fetch acknowledge
- o_fetch_valid  out  1  one-cycle pulse: fetch for o_fetch_pc accepted
- o_fetch_pc  out  WORD_SIZE  PC of the completed fetch
- o_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, INIT, NEXT, READ, LATCH, REQ.
- IDLE: all pc_reg controls 0. i_start=1 moves to INIT.
- INIT: cs=1, we=1, o_pc_d=RESET_VECTOR. Always moves to READ.
- READ: cs=1, oe=1, we=0. The pc_reg output updates on this edge. Always moves to LATCH.
- LATCH: cs=0. Sample i_pc_q into r_pc. Always moves to REQ.
- REQ: o_imem_req=1, o_imem_addr=r_pc. Waits for i_imem_ack. On ack: pulse o_fetch_valid with o_fetch_pc=r_pc, then go to NEXT.
- NEXT: selected in this priority order:
  - i_halt=1: go to IDLE, no write.
  - i_stall=1: stay in NEXT, no write.
  - Otherwise: cs=1, we=1, o_pc_d = branch-pending ? r_target : r_pc+PC_STEP. Clear branch-pending and go to READ.
- we and oe are never asserted in the same cycle. i_pc_q is sampled only in LATCH; it is high-Z after pc_reg reset.
- Branch capture: i_branch_valid in any non-IDLE state sets branch-pending and loads r_target. A later strobe overwrites r_target (last wins). A strobe in the same cycle as the NEXT write is captured for the following fetch, not the current one. Strobes in IDLE are ignored.
- Arithmetic: r_pc+PC_STEP is modulo 2^WORD_SIZE; the carry is dropped.
- i_start outside IDLE is ignored. i_halt is only acted on in NEXT.
- Reset (asynchronous, any state): go to IDLE. All outputs 0 (o_pc_d=0, o_fetch_pc=0). r_pc, r_target and branch-pending are cleared. An outstanding imem request is dropped; a late ack arriving in IDLE is ignored.

## Timing
- Start to first o_imem_req: 3 cycles after the i_start edge (INIT, READ, LATCH).
- Steady state: 4 cycles per fetch with a zero-wait ack (NEXT, READ, LATCH, REQ). Each imem wait cycle adds 1.
- o_fetch_valid asserts in the same cycle as i_imem_ack (combinational from REQ && ack). o_fetch_pc is registered and stable in that cycle.
- o_imem_addr and o_imem_req hold constant from REQ entry until the ack cycle.
- Branch latency: a strobe taken before the NEXT write cycle takes effect on that write. The target reaches o_imem_addr 3 cycles later.

## Structure
- Shared package: state encoding constants (ST_IDLE..ST_REQ, 3-bit) and the default PC_STEP/RESET_VECTOR values.
- Single FSM module, no sub-module. An optional testbench wrapper instantiates pc_fetch_ctrl with pc_reg for integration.

## Test plan
- Reset then start, ack always high → o_imem_addr sequence 0x0, 0x4, 0x8 with o_fetch_valid every 4 cycles; first req 3 cycles after start.
- Branch strobe target 0x100 during REQ for 0x8 → next fetch address 0x100, then 0x104.
- Two strobes 0x200 then 0x300 before NEXT → fetch 0x300 only.
- i_stall high 5 cycles in NEXT → no pc_reg write, o_imem_req low; resumes at PC+4 after stall drops.
- RESET_VECTOR=0xFFFFFFF8, PC_STEP=4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
- i_rst low while REQ waiting (ack withheld) → all outputs 0 and IDLE immediately; later ack gives no o_fetch_valid; a new start refetches RESET_VECTOR.
